trigger_sequencer: RTL and testbench
====================================

Name: trigger_sequencer

Overview:
- Per-channel trigger controller placed directly upstream of the m_axis_IF acquisition datapath.
- Watches the RF Data Converter AXI-Stream sample bus and compares each ADC lane against a threshold.
- On a hit, drives TRIGGERD_FLAG for a fixed acquisition window and presents a latched TIME_STAMP.
- Enforces the pre-trigger fill, a dead time between events and an abort when the downstream buffer reports full; keeps event and drop counters for software.

Parameters:
- THRESHOLD, 10: trigger level as a percentage of 2^ADC_RESOLUTION_WIDTH. Level = THRESHOLD*2^ADC_RESOLUTION_WIDTH/100, integer, computed at elaboration.
- PRE_ACQUI_LEN, 12: number of valid beats that must be in the ring buffer before arming.
- POST_ACQUI_LEN, 38: beats after the trigger beat.
- DEADTIME, 8: minimum number of cycles TRIGGERD_FLAG stays low between windows.
- TIME_STAMP_WIDTH, 16: width of the free-running counter and of TIME_STAMP.
- ADC_RESOLUTION_WIDTH, 12: valid bits per sample lane (lane LSBs).
- SAMPLE_WIDTH, 16: lane pitch on S_AXIS_TDATA.
- S_AXIS_TDATA_WIDTH, 128: input bus width. Lanes = S_AXIS_TDATA_WIDTH/SAMPLE_WIDTH.
- CNT_WIDTH, 32: width of the event and drop counters.

Ports:
- AXIS_ACLK  in  1  the single clock.
- AXIS_ARESET  in  1  synchronous reset, active-high.
- ENABLE  in  1  arms the trigger; while low, no new window starts.
- S_AXIS_TDATA  in  S_AXIS_TDATA_WIDTH  ADC sample beat.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  in  1  beat accepted (monitored only, never driven).
- FIFO_FULL  in  1  O_FIFO_FULL from the datapath.
- TRIGGERD_FLAG  out  1  acquisition window to the datapath.
- TIME_STAMP  out  TIME_STAMP_WIDTH  timestamp of the trigger beat.
- BUSY  out  1  high in every state other than ARMED.
- EVENT_CNT  out  CNT_WIDTH  number of windows that completed.
- DROP_CNT  out  CNT_WIDTH  number of hits lost, either while not ARMED with ENABLE=1 or by FIFO abort.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (AXIS_ACLK, AXIS_ARESET).
- Reset values: all outputs 0 (TRIGGERD_FLAG, TIME_STAMP, BUSY, EVENT_CNT, DROP_CNT); state FILL; all counters 0.
- Beat: beat = S_AXIS_TVALID & S_AXIS_TREADY.
- Hit:
  - hit = beat AND any lane, unsigned S_AXIS_TDATA[SAMPLE_WIDTH*i +: ADC_RESOLUTION_WIDTH], strictly greater than Level.
  - Combinational compare feeds a registered decision.
- Free-running timestamp counter: increments every cycle, wraps 2^TIME_STAMP_WIDTH-1 -> 0, and is not gated by ENABLE.
- FSM:
  - FILL: count beats. When the count reaches PRE_ACQUI_LEN -> ARMED. BUSY=1.
  - ARMED: on hit & ENABLE & !FIFO_FULL -> ACQUIRE. Latch TIME_STAMP = counter value in the hit cycle. TRIGGERD_FLAG rises on the next edge (latency 1).
  - ACQUIRE:
    - TRIGGERD_FLAG=1 for exactly PRE_ACQUI_LEN+POST_ACQUI_LEN+1 cycles. TIME_STAMP is held stable.
    - On normal end: EVENT_CNT+1 -> DEAD.
    - If FIFO_FULL=1 in any cycle: TRIGGERD_FLAG drops the next edge, DROP_CNT+1 -> DEAD. EVENT_CNT is not incremented.
  - DEAD: TRIGGERD_FLAG=0 for DEADTIME cycles, then -> FILL (the pre-buffer is refilled).
- Hit outside ARMED while ENABLE=1: DROP_CNT+1. Hits while ENABLE=0 are ignored.
- Simultaneous events:
  - Hit in ARMED while FIFO_FULL=1: no window, DROP_CNT+1.
  - ENABLE falling mid-ACQUIRE: the window completes normally.
- Counters EVENT_CNT and DROP_CNT saturate at all-ones; they do not wrap.
- Reset asserted mid-ACQUIRE: TRIGGERD_FLAG is 0 on the next edge; counters clear.
- TIME_STAMP keeps its last value outside ACQUIRE.

Decomposition:
- Shared package trigger_pkg: state encoding (FILL, ARMED, ACQUIRE, DEAD) and the level computation function used by both RTL and bench.
- Sub-module threshold_cmp: lane split and unsigned compare that produces hit. The FSM, timestamp and counters stay in the top module.

Test Plan:
- Reset, then 12 beats of 0x000 -> BUSY falls after the 12th beat; TRIGGERD_FLAG stays 0.
- ARMED, a single lane 3 at 0x19A (>409) at timestamp 0x0123 -> TRIGGERD_FLAG high the next cycle for 51 cycles; TIME_STAMP=0x0123; EVENT_CNT=1.
- A lane exactly 0x199 (=409) -> no trigger, since the compare is strict.
- FIFO_FULL asserted at window cycle 20 -> TRIGGERD_FLAG low the next cycle; DROP_CNT=1; EVENT_CNT=0; re-arm after 8+12 cycles.
- Second hit during DEAD with ENABLE=1 -> DROP_CNT increments; no window. Same hit with ENABLE=0 -> no change.
- Timestamp counter preset to 0xFFFF, hit -> TIME_STAMP=0xFFFF; the next event shows the wrapped value.

Source files
------------

// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - trigger sequencer state encoding and trigger level helper
package trigger_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ARMED   = 2'd1,
        ACQUIRE = 2'd2,
        DEAD    = 2'd3
    } trig_state_e;

    // Level as a percentage of full scale, truncated toward zero.
    function automatic int calc_level(input int threshold_pct, input int adc_width);
        return (threshold_pct * (1 << adc_width)) / 100;
    endfunction

endpackage

// File: rtl/threshold_cmp.sv
// rtl/threshold_cmp.sv - splits a sample beat into lanes and flags any lane strictly above the level
module threshold_cmp #(
    parameter int LANES        = 8,
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADC_WIDTH    = 12,
    parameter int LEVEL        = 409
) (
    input  logic [LANES*SAMPLE_WIDTH-1:0] tdata,
    input  logic                          beat,
    output logic                          hit
);

    // One extra bit so a level of exactly full scale never aliases to zero.
    localparam logic [ADC_WIDTH:0] LEVEL_EXT = (ADC_WIDTH + 1)'(LEVEL);

    logic [LANES-1:0] lane_over;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [ADC_WIDTH-1:0] lane;

        assign lane         = tdata[SAMPLE_WIDTH*i +: ADC_WIDTH];
        assign lane_over[i] = ({1'b0, lane} > LEVEL_EXT);

        if (SAMPLE_WIDTH > ADC_WIDTH) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^tdata[SAMPLE_WIDTH*i+ADC_WIDTH +: SAMPLE_WIDTH-ADC_WIDTH];
        end
    end

    assign hit = beat & (|lane_over);

endmodule

// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - threshold trigger FSM with timestamp latch and saturating event/drop counters
module trigger_sequencer
    import trigger_pkg::*;
#(
    parameter int THRESHOLD            = 10,
    parameter int PRE_ACQUI_LEN        = 12,
    parameter int POST_ACQUI_LEN       = 38,
    parameter int DEADTIME             = 8,
    parameter int TIME_STAMP_WIDTH     = 16,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int SAMPLE_WIDTH         = 16,
    parameter int S_AXIS_TDATA_WIDTH   = 128,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESET,
    input  logic                          ENABLE,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    input  logic                          S_AXIS_TREADY,
    input  logic                          FIFO_FULL,
    output logic                          TRIGGERD_FLAG,
    output logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
    output logic                          BUSY,
    output logic [CNT_WIDTH-1:0]          EVENT_CNT,
    output logic [CNT_WIDTH-1:0]          DROP_CNT
);

    localparam int LANES   = S_AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
    localparam int LEVEL   = calc_level(THRESHOLD, ADC_RESOLUTION_WIDTH);
    localparam int WIN_LEN = PRE_ACQUI_LEN + POST_ACQUI_LEN + 1;
    localparam int FILL_W  = $clog2(PRE_ACQUI_LEN + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);
    localparam int DEAD_W  = $clog2(DEADTIME + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PRE_ACQUI_LEN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);

    trig_state_e                 state_q, state_d;
    logic [FILL_W-1:0]           fill_cnt_q, fill_cnt_d;
    logic [WIN_W-1:0]            win_cnt_q, win_cnt_d;
    logic [DEAD_W-1:0]           dead_cnt_q, dead_cnt_d;
    logic                        flag_q, flag_d;
    logic                        busy_q, busy_d;
    logic [TIME_STAMP_WIDTH-1:0] ts_cnt_q, ts_cnt_d;
    logic [TIME_STAMP_WIDTH-1:0] ts_q, ts_d;
    logic [CNT_WIDTH-1:0]        event_cnt_q, event_cnt_d;
    logic [CNT_WIDTH-1:0]        drop_cnt_q, drop_cnt_d;

    logic           beat;
    logic           hit;
    logic           hit_en;
    logic           event_inc;
    logic           drop_hit;
    logic           drop_abort;
    logic [CNT_WIDTH:0] event_sum;
    logic [CNT_WIDTH:0] drop_sum;

    assign beat   = S_AXIS_TVALID & S_AXIS_TREADY;
    assign hit_en = hit & ENABLE;

    threshold_cmp #(
        .LANES        (LANES),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .ADC_WIDTH    (ADC_RESOLUTION_WIDTH),
        .LEVEL        (LEVEL)
    ) u_threshold_cmp (
        .tdata (S_AXIS_TDATA[LANES*SAMPLE_WIDTH-1:0]),
        .beat  (beat),
        .hit   (hit)
    );

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        win_cnt_d  = win_cnt_q;
        dead_cnt_d = dead_cnt_q;
        flag_d     = 1'b0;
        ts_d       = ts_q;
        event_inc  = 1'b0;
        drop_hit   = 1'b0;
        drop_abort = 1'b0;

        case (state_q)
            FILL: begin
                drop_hit = hit_en;
                if (beat) begin
                    if (fill_cnt_q == FILL_LAST) begin
                        state_d    = ARMED;
                        fill_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    end
                end
            end
            ARMED: begin
                if (hit_en) begin
                    if (FIFO_FULL) begin
                        drop_hit = 1'b1;
                    end else begin
                        state_d   = ACQUIRE;
                        flag_d    = 1'b1;
                        win_cnt_d = '0;
                        ts_d      = ts_cnt_q;
                    end
                end
            end
            ACQUIRE: begin
                drop_hit = hit_en;
                // A full FIFO wins over a window that would end this same cycle.
                if (FIFO_FULL) begin
                    drop_abort = 1'b1;
                    state_d    = DEAD;
                    dead_cnt_d = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    event_inc  = 1'b1;
                    state_d    = DEAD;
                    dead_cnt_d = '0;
                end else begin
                    flag_d    = 1'b1;
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end
            DEAD: begin
                drop_hit = hit_en;
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d    = FILL;
                    fill_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q + DEAD_W'(1);
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_comb begin
        busy_d   = (state_d != ARMED);
        ts_cnt_d = ts_cnt_q + TIME_STAMP_WIDTH'(1);

        // Widened sums saturate at all-ones instead of wrapping.
        event_sum   = {1'b0, event_cnt_q} + (CNT_WIDTH + 1)'(event_inc);
        drop_sum    = {1'b0, drop_cnt_q} + (CNT_WIDTH + 1)'(drop_hit)
                    + (CNT_WIDTH + 1)'(drop_abort);
        event_cnt_d = event_sum[CNT_WIDTH] ? '1 : event_sum[CNT_WIDTH-1:0];
        drop_cnt_d  = drop_sum[CNT_WIDTH]  ? '1 : drop_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            win_cnt_q   <= '0;
            dead_cnt_q  <= '0;
            flag_q      <= 1'b0;
            busy_q      <= 1'b0;
            ts_cnt_q    <= '0;
            ts_q        <= '0;
            event_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            win_cnt_q   <= win_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
            flag_q      <= flag_d;
            busy_q      <= busy_d;
            ts_cnt_q    <= ts_cnt_d;
            ts_q        <= ts_d;
            event_cnt_q <= event_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign TRIGGERD_FLAG = flag_q;
    assign TIME_STAMP    = ts_q;
    assign BUSY          = busy_q;
    assign EVENT_CNT     = event_cnt_q;
    assign DROP_CNT      = drop_cnt_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb/tb_trigger_sequencer.sv - scoreboard bench for trigger_sequencer
module tb_trigger_sequencer;

    localparam int TSW = 16;
    localparam int CW  = 32;
    localparam int DW  = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          fifo_full;
    logic          flag;
    logic [TSW-1:0] ts_out;
    logic          busy;
    logic [CW-1:0] event_cnt;
    logic [CW-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0]  exp_event = '0;
    logic [CW-1:0]  exp_drop  = '0;
    logic [TSW-1:0] ts_model  = '0;

    typedef struct {
        logic [TSW-1:0] ts;
        int             len;
    } win_t;
    win_t exp_q[$];

    logic           in_win  = 1'b0;
    int             win_len = 0;
    logic [TSW-1:0] win_ts  = '0;

    always #5 clk = ~clk;

    always @(posedge clk) ts_model <= rst ? '0 : ts_model + 16'd1;

    trigger_sequencer #(
        .THRESHOLD            (10),
        .PRE_ACQUI_LEN        (12),
        .POST_ACQUI_LEN       (38),
        .DEADTIME             (8),
        .TIME_STAMP_WIDTH     (TSW),
        .ADC_RESOLUTION_WIDTH (12),
        .SAMPLE_WIDTH         (16),
        .S_AXIS_TDATA_WIDTH   (DW),
        .CNT_WIDTH            (CW)
    ) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .ENABLE        (enable),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .FIFO_FULL     (fifo_full),
        .TRIGGERD_FLAG (flag),
        .TIME_STAMP    (ts_out),
        .BUSY          (busy),
        .EVENT_CNT     (event_cnt),
        .DROP_CNT      (drop_cnt)
    );

    // Window monitor: measures each flag pulse and checks it against the scoreboard.
    always @(negedge clk) begin
        if (flag === 1'b1) begin
            if (!in_win) begin
                in_win  = 1'b1;
                win_len = 0;
                win_ts  = ts_out;
            end
            win_len++;
            total++;
            if (ts_out !== win_ts) begin
                bad++;
                $display("FAIL ts_stable: got %0h want %0h", ts_out, win_ts);
            end
        end else if (in_win) begin
            win_t e;
            in_win = 1'b0;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_window: got len %0d want none", win_len);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (win_len !== e.len) begin
                    bad++;
                    $display("FAIL window_len: got %0d want %0d", win_len, e.len);
                end
                if (win_ts !== e.ts) begin
                    bad++;
                    $display("FAIL window_ts: got %0h want %0h", win_ts, e.ts);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        tdata  = '0;
        tvalid = 1'b1;
        tready = 1'b1;
    endtask

    task automatic hit_beat(input int lane, input logic [15:0] v);
        tdata = '0;
        tdata[lane*16 +: 16] = v;
        tvalid = 1'b1;
        tready = 1'b1;
    endtask

    task automatic wait_ts(input logic [TSW-1:0] target);
        int n = 0;
        drive_idle();
        while (ts_model !== target && n < 70000) begin
            step();
            n++;
        end
        total++;
        if (ts_model !== target) begin
            bad++;
            $display("FAIL wait_ts_timeout: got %0h want %0h", ts_model, target);
        end
    endtask

    task automatic wait_window_end();
        int n = 0;
        drive_idle();
        while (flag === 1'b1 && n < 200) begin
            step();
            n++;
        end
        total++;
        if (flag !== 1'b0) begin
            bad++;
            $display("FAIL window_end_timeout: got %0b want 0", flag);
        end
    endtask

    task automatic rearm(output int n);
        n = 0;
        drive_idle();
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rearm_timeout: got busy %0b want 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; tdata = '0; tvalid = 1'b0; tready = 1'b1; fifo_full = 1'b0;
        repeat (3) step();
        total += 5;
        if (flag !== 1'b0)     begin bad++; $display("FAIL reset_flag: got %0b want 0", flag); end
        if (ts_out !== '0)     begin bad++; $display("FAIL reset_ts: got %0h want 0", ts_out); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        if (event_cnt !== '0)  begin bad++; $display("FAIL reset_event: got %0d want 0", event_cnt); end
        if (drop_cnt !== '0)   begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        rst = 1'b0;
        step();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_reset: got %0b want 1", busy); end
    endtask

    task automatic test_fill();
        int beats = 0;
        for (int i = 0; i < 15; i++) begin
            drive_idle();
            if (i == 3 || i == 8) tready = 1'b0;
            if (i == 5) tvalid = 1'b0;
            if (tvalid && tready) beats++;
            step();
            total++;
            if (busy !== (beats < 12)) begin
                bad++;
                $display("FAIL fill_busy[%0d]: got %0b want %0b", i, busy, beats < 12);
            end
        end
        total++;
        if (flag !== 1'b0) begin bad++; $display("FAIL fill_flag: got %0b want 0", flag); end
    endtask

    task automatic test_trigger();
        int n;
        wait_ts(16'h0123);
        hit_beat(3, 16'h019A);
        exp_q.push_back('{16'h0123, 51});
        step();
        drive_idle();
        total += 3;
        if (flag !== 1'b1)      begin bad++; $display("FAIL trig_flag: got %0b want 1", flag); end
        if (ts_out !== 16'h0123) begin bad++; $display("FAIL trig_ts: got %0h want 123", ts_out); end
        if (busy !== 1'b1)      begin bad++; $display("FAIL trig_busy: got %0b want 1", busy); end
        wait_window_end();
        exp_event++;
        total += 2;
        if (event_cnt !== exp_event) begin bad++; $display("FAIL trig_event: got %0d want %0d", event_cnt, exp_event); end
        if (drop_cnt !== exp_drop)   begin bad++; $display("FAIL trig_drop: got %0d want %0d", drop_cnt, exp_drop); end
        rearm(n);
        total++;
        if (n !== 20) begin bad++; $display("FAIL trig_rearm_cycles: got %0d want 20", n); end
    endtask

    task automatic test_equal_level();
        logic [DW-1:0] pats [4];
        pats[0] = '0;
        pats[0][5*16 +: 16] = 16'h0199;
        for (int l = 0; l < 8; l++) pats[1][l*16 +: 16] = 16'h0199;
        pats[2] = '0;
        pats[2][1*16 +: 16] = 16'hF199;
        pats[3] = '0;
        pats[3][6*16 +: 16] = 16'hF000;
        for (int p = 0; p < 4; p++) begin
            tdata = pats[p]; tvalid = 1'b1; tready = 1'b1;
            step();
            total += 2;
            if (flag !== 1'b0) begin bad++; $display("FAIL equal_flag[%0d]: got %0b want 0", p, flag); end
            if (busy !== 1'b0) begin bad++; $display("FAIL equal_busy[%0d]: got %0b want 0", p, busy); end
        end
        drive_idle();
        step();
        total++;
        if (drop_cnt !== exp_drop) begin bad++; $display("FAIL equal_drop: got %0d want %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_abort();
        int n;
        fifo_full = 1'b1;
        hit_beat(0, 16'h0FFF);
        step();
        drive_idle();
        exp_drop++;
        total += 3;
        if (flag !== 1'b0) begin bad++; $display("FAIL armed_full_flag: got %0b want 0", flag); end
        if (busy !== 1'b0) begin bad++; $display("FAIL armed_full_busy: got %0b want 0", busy); end
        if (drop_cnt !== exp_drop) begin bad++; $display("FAIL armed_full_drop: got %0d want %0d", drop_cnt, exp_drop); end
        fifo_full = 1'b0;
        hit_beat(0, 16'h0FFF);
        exp_q.push_back('{ts_model, 20});
        step();
        drive_idle();
        repeat (19) step();
        total++;
        if (flag !== 1'b1) begin bad++; $display("FAIL abort_pre_flag: got %0b want 1", flag); end
        fifo_full = 1'b1;
        step();
        exp_drop++;
        total += 3;
        if (flag !== 1'b0) begin bad++; $display("FAIL abort_flag: got %0b want 0", flag); end
        if (drop_cnt !== exp_drop)   begin bad++; $display("FAIL abort_drop: got %0d want %0d", drop_cnt, exp_drop); end
        if (event_cnt !== exp_event) begin bad++; $display("FAIL abort_event: got %0d want %0d", event_cnt, exp_event); end
        fifo_full = 1'b0;
        rearm(n);
        total++;
        if (n !== 20) begin bad++; $display("FAIL abort_rearm_cycles: got %0d want 20", n); end
    endtask

    task automatic test_dead_hit();
        int n;
        hit_beat(7, 16'h0800);
        exp_q.push_back('{ts_model, 51});
        step();
        wait_window_end();
        exp_event++;
        hit_beat(7, 16'h0800);
        step();
        exp_drop++;
        total += 2;
        if (drop_cnt !== exp_drop) begin bad++; $display("FAIL dead_hit_drop: got %0d want %0d", drop_cnt, exp_drop); end
        if (flag !== 1'b0) begin bad++; $display("FAIL dead_hit_flag: got %0b want 0", flag); end
        enable = 1'b0;
        step();
        total++;
        if (drop_cnt !== exp_drop) begin bad++; $display("FAIL dead_disabled_drop: got %0d want %0d", drop_cnt, exp_drop); end
        enable = 1'b1;
        rearm(n);
        total += 2;
        if (n !== 18) begin bad++; $display("FAIL dead_rearm_cycles: got %0d want 18", n); end
        if (event_cnt !== exp_event) begin bad++; $display("FAIL dead_event: got %0d want %0d", event_cnt, exp_event); end
    endtask

    task automatic test_enable();
        int n;
        enable = 1'b0;
        hit_beat(2, 16'h0500);
        step();
        total += 3;
        if (flag !== 1'b0) begin bad++; $display("FAIL disabled_flag: got %0b want 0", flag); end
        if (busy !== 1'b0) begin bad++; $display("FAIL disabled_busy: got %0b want 0", busy); end
        if (drop_cnt !== exp_drop) begin bad++; $display("FAIL disabled_drop: got %0d want %0d", drop_cnt, exp_drop); end
        enable = 1'b1;
        exp_q.push_back('{ts_model, 51});
        step();
        drive_idle();
        enable = 1'b0;
        total++;
        if (flag !== 1'b1) begin bad++; $display("FAIL enable_fall_flag: got %0b want 1", flag); end
        wait_window_end();
        exp_event++;
        total++;
        if (event_cnt !== exp_event) begin bad++; $display("FAIL enable_fall_event: got %0d want %0d", event_cnt, exp_event); end
        enable = 1'b1;
        rearm(n);
    endtask

    task automatic test_wrap();
        int n;
        logic [TSW-1:0] t;
        wait_ts(16'hFFFF);
        hit_beat(4, 16'h0300);
        exp_q.push_back('{16'hFFFF, 51});
        step();
        drive_idle();
        total++;
        if (ts_out !== 16'hFFFF) begin bad++; $display("FAIL wrap_ts_max: got %0h want ffff", ts_out); end
        wait_window_end();
        exp_event++;
        rearm(n);
        t = ts_model;
        hit_beat(1, 16'h019A);
        exp_q.push_back('{t, 51});
        step();
        drive_idle();
        total += 2;
        if (ts_out !== t) begin bad++; $display("FAIL wrap_ts_next: got %0h want %0h", ts_out, t); end
        if (ts_out >= 16'h0100) begin bad++; $display("FAIL wrap_ts_small: got %0h want below 100", ts_out); end
        wait_window_end();
        exp_event++;
        total++;
        if (event_cnt !== exp_event) begin bad++; $display("FAIL wrap_event: got %0d want %0d", event_cnt, exp_event); end
        rearm(n);
    endtask

    task automatic test_reset_mid();
        hit_beat(0, 16'h01FF);
        exp_q.push_back('{ts_model, 10});
        step();
        drive_idle();
        repeat (9) step();
        rst = 1'b1;
        step();
        total += 5;
        if (flag !== 1'b0)    begin bad++; $display("FAIL midreset_flag: got %0b want 0", flag); end
        if (event_cnt !== '0) begin bad++; $display("FAIL midreset_event: got %0d want 0", event_cnt); end
        if (drop_cnt !== '0)  begin bad++; $display("FAIL midreset_drop: got %0d want 0", drop_cnt); end
        if (ts_out !== '0)    begin bad++; $display("FAIL midreset_ts: got %0h want 0", ts_out); end
        if (busy !== 1'b0)    begin bad++; $display("FAIL midreset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        exp_event = '0;
        exp_drop  = '0;
        repeat (2) step();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_empty: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_trigger();
        test_equal_level();
        test_abort();
        test_dead_hit();
        test_enable();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
